gpmc_sync_master: RTL

GPMC_SYNC_MASTER -- requirements
Module: gpmc_sync_master

---
 rtl/gpmc_sync_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gpmc_sync_master.sv
// Synchronous GPMC bus master: one request at a time, muxed address/data,
// bus strobes launched on gpmc_clk falling edges so the responder samples mid-period.
module gpmc_sync_master #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int RD_WAIT     = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_is_wr,
  input  logic [ADDR_WIDTH:0]   addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_done,
  output logic                  gpmc_clk,
  output logic                  gpmc_cs_n,
  output logic                  gpmc_adv_n,
  output logic                  gpmc_we_n,
  output logic                  gpmc_oe_n,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, TURN} state_t;

  localparam logic [3:0] RD_LAST   = 4'(RD_WAIT - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  gclk_q, pend_q, pend_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cs_n_q, cs_n_d, adv_n_q, adv_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic [DATA_WIDTH-1:0] ad_out_q, ad_out_d, rd_data_q, rd_data_d;
  logic                  ad_oe_q, ad_oe_d, rd_valid_q, rd_valid_d, wr_done_q, wr_done_d;
  logic                  fall, accept, unused_addr_lsb;

  // gpmc_clk is high in the cycle before a fall edge, so that edge is a fall edge.
  assign fall            = gclk_q;
  assign ready           = (state_q == IDLE) && !pend_q;
  assign accept          = req && ready;
  assign unused_addr_lsb = addr[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gclk_q     <= 1'b0;
      pend_q     <= 1'b0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cs_n_q     <= 1'b1;
      adv_n_q    <= 1'b1;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      ad_out_q   <= '0;
      ad_oe_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gclk_q     <= ~gclk_q;
      pend_q     <= pend_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cs_n_q     <= cs_n_d;
      adv_n_q    <= adv_n_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      pend_d  = 1'b1;
      is_wr_d = req_is_wr;
      addr_d  = addr[ADDR_WIDTH:1];
      wdata_d = wr_data;
    end
    if (fall) begin
      case (state_q)
        IDLE: if (pend_q) begin
          state_d = ADDR;
          pend_d  = 1'b0;
        end
        ADDR: begin
          state_d = is_wr_q ? WDATA : RWAIT;
          cnt_d   = '0;
        end
        WDATA: begin
          state_d = (TURN_CYCLES == 0) ? IDLE : TURN;
          cnt_d   = '0;
        end
        RWAIT: if (cnt_q == RD_LAST) begin
          state_d = (TURN_CYCLES == 0) ? IDLE : TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        TURN: if (cnt_q == TURN_LAST) state_d = IDLE;
              else cnt_d = cnt_q + 4'd1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus pins are registered from the next state; state only moves on fall edges.
  always_comb begin
    cs_n_d     = 1'b1;
    adv_n_d    = 1'b1;
    we_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    ad_out_d   = '0;
    ad_oe_d    = 1'b0;
    case (state_d)
      ADDR: begin
        cs_n_d   = 1'b0;
        adv_n_d  = 1'b0;
        ad_out_d = DATA_WIDTH'(addr_q);
        ad_oe_d  = 1'b1;
      end
      WDATA: begin
        cs_n_d   = 1'b0;
        we_n_d   = 1'b0;
        ad_out_d = wdata_q;
        ad_oe_d  = 1'b1;
      end
      RWAIT: begin
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      default: ;
    endcase
    wr_done_d  = fall && (state_q == WDATA);
    rd_valid_d = fall && (state_q == RWAIT) && (cnt_q == RD_LAST);
    rd_data_d  = rd_valid_d ? gpmc_ad_in : rd_data_q;
  end

  assign gpmc_clk    = gclk_q;
  assign gpmc_cs_n   = cs_n_q;
  assign gpmc_adv_n  = adv_n_q;
  assign gpmc_we_n   = we_n_q;
  assign gpmc_oe_n   = oe_n_q;
  assign gpmc_ad_out = ad_out_q;
  assign gpmc_ad_oe  = ad_oe_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign wr_done     = wr_done_q;

endmodule
